// File: rtl/dram.sv
//==============================================================================
// Module      : dram
// Description : Fixed-latency line-wide main-memory model behind the L1 data
//               cache. One data_width-bit line per request, accepted on cs and
//               completed with a single-cycle ack after `delay` edges.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dram #(
    parameter int data_width = 256,
    parameter int mem_size   = 2048,
    parameter int delay      = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           addr_i,
    input  logic [data_width-1:0] data_i,
    input  logic                  cs,
    input  logic                  we,
    output logic                  ack,
    output logic [data_width-1:0] data_o
);

    // A zero latency would make BUSY meaningless, so it behaves as one cycle.
    localparam int delay_eff = (delay < 1) ? 1 : delay;
    localparam int idx_width = (mem_size > 1) ? $clog2(mem_size) : 1;
    localparam int cnt_width = $clog2(delay_eff + 1);
    localparam int idx_lsb   = 5;
    localparam int idx_msb   = idx_lsb + idx_width - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t                state;
    logic [cnt_width-1:0]  counter;
    logic [idx_width-1:0]  idx_q;
    logic                  we_q;
    logic [data_width-1:0] wdata_q;
    logic                  cnt_done;

    // Line storage; deliberately not reset so contents survive rst.
    logic [data_width-1:0] memory [mem_size];

    assign cnt_done = (counter == cnt_width'(delay_eff));

    // Byte-offset bits and bits above the index are intentionally discarded,
    // which gives the modulo-mem_size wrap of the line address.
    logic unused_addr_bits;
    generate
        if (idx_msb < 31) begin : g_addr_high
            assign unused_addr_bits = ^{addr_i[idx_lsb-1:0], addr_i[31:idx_msb+1]};
        end else begin : g_addr_full
            assign unused_addr_bits = ^addr_i[idx_lsb-1:0];
        end
    endgenerate

    // Commit a latched write on the completing edge; gating on rst keeps an
    // aborted transaction from ever landing.
    always_ff @(posedge clk) begin
        if (rst && (state == S_BUSY) && cnt_done && we_q) begin
            memory[idx_q] <= wdata_q;
        end
    end

    // Request/ack controller: latch the request, count out the latency,
    // publish read data together with a one-cycle ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            counter <= '0;
            ack     <= 1'b0;
            data_o  <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    ack <= 1'b0;
                    if (cs) begin
                        idx_q   <= addr_i[idx_msb:idx_lsb];
                        we_q    <= we;
                        wdata_q <= data_i;
                        counter <= cnt_width'(1);
                        state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cnt_done) begin
                        // Clear rather than wrap so the counter never aliases.
                        counter <= '0;
                        ack     <= 1'b1;
                        state   <= S_ACK;
                        if (!we_q) begin
                            data_o <= memory[idx_q];
                        end
                    end else begin
                        counter <= counter + cnt_width'(1);
                    end
                end
                S_ACK: begin
                    // No acceptance here: a held cs is picked up from IDLE.
                    ack   <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    ack   <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dram.sv
//==============================================================================
// Module      : tb_dram
// Description : Directed self-checking bench for the dram line memory model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dram;

    logic         clk;
    logic         rst;
    logic [31:0]  addr_i;
    logic [255:0] data_i;
    logic         cs;
    logic         we;
    logic         ack;
    logic [255:0] data_o;

    int checks;
    int errors;

    dram #(
        .data_width(256),
        .mem_size  (2048),
        .delay     (10)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .addr_i(addr_i),
        .data_i(data_i),
        .cs    (cs),
        .we    (we),
        .ack   (ack),
        .data_o(data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present a request and return just after the accepting edge.
    task automatic start(input logic [31:0] a, input logic [255:0] d, input logic w);
        @(negedge clk);
        addr_i = a;
        data_i = d;
        we     = w;
        cs     = 1'b1;
        @(posedge clk);
    endtask

    // Count edges until ack is seen (sampled 1 time unit after each edge).
    task automatic wait_ack(input string tag, output int n);
        bit seen;
        seen = 1'b0;
        n    = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (ack) seen = 1'b1;
        end
        if (!seen) check({tag, "_ack_timeout"}, 256'(0), 256'(1));
    endtask

    // Drop cs and confirm the ack pulse lasted exactly one cycle.
    task automatic end_txn(input string tag);
        cs = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_ack_width"}, 256'(ack), 256'(0));
    endtask

    task automatic txn(input string tag, input logic [31:0] a, input logic [255:0] d,
                       input logic w);
        int n;
        start(a, d, w);
        wait_ack(tag, n);
        check({tag, "_latency"}, 256'(n), 256'(10));
        end_txn(tag);
    endtask

    initial begin
        int n1;
        int n2;
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        cs     = 1'b0;
        we     = 1'b0;
        addr_i = '0;
        data_i = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_ack", 256'(ack), 256'(0));
        check("reset_data_o", data_o, 256'(0));
        @(negedge clk);
        rst = 1'b1;

        // 1: preload line 0 with 5, then read it back
        txn("wr0", 32'h0000_0000, 256'h5, 1'b1);
        check("wr0_mem0", dut.memory[0], 256'h5);
        check("wr0_data_o_kept", data_o, 256'(0));
        txn("rd0", 32'h0000_0000, '0, 1'b0);
        check("rd0_data", data_o, 256'h5);

        // 2: write line 1, data_o must not move, then read it
        txn("wr1", 32'h0000_0020, 256'hDEADBEEF, 1'b1);
        check("wr1_mem1", dut.memory[1], 256'hDEADBEEF);
        check("wr1_data_o_kept", data_o, 256'h5);
        txn("rd1", 32'h0000_0020, '0, 1'b0);
        check("rd1_data", data_o, 256'hDEADBEEF);

        // 3: inputs changed (and cs dropped) during BUSY are ignored
        txn("wr3", 32'h0000_0060, 256'h3333, 1'b1);
        start(32'h0000_0040, {8'hA5, 240'h0, 8'h5A}, 1'b1);
        #1;
        addr_i = 32'h0000_0060;
        data_i = 256'hBAD;
        we     = 1'b0;
        cs     = 1'b0;
        wait_ack("wr2", n1);
        check("wr2_latency", 256'(n1), 256'(10));
        end_txn("wr2");
        check("wr2_mem2", dut.memory[2], {8'hA5, 240'h0, 8'h5A});
        check("wr2_mem3_untouched", dut.memory[3], 256'h3333);
        check("wr2_data_o_kept", data_o, 256'hDEADBEEF);

        // 4: back-to-back reads with cs held high
        txn("wr32", 32'h0000_0400, {8'h77, 240'h0, 8'h32}, 1'b1);
        start(32'h0000_0000, '0, 1'b0);
        wait_ack("b2b_first", n1);
        check("b2b_first_latency", 256'(n1), 256'(10));
        check("b2b_first_data", data_o, 256'h5);
        addr_i = 32'h0000_0400;
        wait_ack("b2b_second", n2);
        check("b2b_spacing", 256'(n2), 256'(12));
        check("b2b_second_data", data_o, {8'h77, 240'h0, 8'h32});
        end_txn("b2b");

        // 5: reset in the middle of a write aborts it
        start(32'h0000_0060, 256'h999, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        cs  = 1'b0;
        rst = 1'b0;
        #1;
        check("abort_ack", 256'(ack), 256'(0));
        check("abort_data_o", data_o, 256'(0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            check("abort_no_ack", 256'(ack), 256'(0));
        end
        check("abort_mem3", dut.memory[3], 256'h3333);
        txn("rd3", 32'h0000_0060, '0, 1'b0);
        check("rd3_data", data_o, 256'h3333);

        // 6: address above the index range wraps to line 0
        txn("rdwrap", 32'h0001_0000, '0, 1'b0);
        check("rdwrap_data", data_o, 256'h5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
